// File: rtl/iir_pkg.sv
// Shared types and defaults for the IIR filter output path.
package iir_pkg;

  localparam int DEF_SIGNAL_BITS = 24;

  typedef logic signed [DEF_SIGNAL_BITS-1:0] sample_t;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_e;

endpackage

// File: rtl/decim_hold_reg.sv
// One-deep valid/ready holding register for completed block averages.
//   state     | meaning
//   OUT_EMPTY | no result pending; a load captures data
//   OUT_FULL  | avg_o holds an unconsumed result; a load without ready is dropped
module decim_hold_reg
  import iir_pkg::*;
#(
  parameter int W = DEF_SIGNAL_BITS
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                load,
  input  logic signed [W-1:0] data,
  input  logic                avg_ready_i,
  output logic                drop,
  output logic signed [W-1:0] avg_o,
  output logic                avg_valid_o
);

  out_state_e state, state_nxt;
  logic       capture;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= OUT_EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (load) state_nxt = OUT_FULL;
      OUT_FULL:  if (avg_ready_i && !load) state_nxt = OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

  always_comb begin
    avg_valid_o = (state == OUT_FULL);
    capture     = load && ((state == OUT_EMPTY) || avg_ready_i);
    drop        = load && (state == OUT_FULL) && !avg_ready_i;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)     avg_o <= '0;
    else if (capture) avg_o <= data;
  end

endmodule

// File: rtl/iir_output_decimator.sv
// Boxcar-averages DECIM filter samples into one rounded result per block and
// presents it on a one-deep valid/ready register, counting blocks lost to back-pressure.
module iir_output_decimator
  import iir_pkg::*;
#(
  parameter int SIGNAL_BITS = DEF_SIGNAL_BITS,
  parameter int DECIM       = 16,
  parameter int DROP_BITS   = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          clear_i,
  input  logic signed [SIGNAL_BITS-1:0] sample_i,
  input  logic                          sample_valid_i,
  output logic signed [SIGNAL_BITS-1:0] avg_o,
  output logic                          avg_valid_o,
  input  logic                          avg_ready_i,
  output logic                          overrun_o,
  output logic [DROP_BITS-1:0]          drop_count_o
);

  localparam int LOG2     = $clog2(DECIM);
  localparam int ACC_BITS = SIGNAL_BITS + LOG2;

  logic signed [ACC_BITS-1:0]    acc;
  logic signed [ACC_BITS-1:0]    sum;
  logic [LOG2-1:0]               cnt;
  logic                          last;
  logic                          blk_done;
  logic signed [SIGNAL_BITS-1:0] result;
  logic                          drop;

  assign sum      = acc + ACC_BITS'(sample_i);
  assign last     = (cnt == LOG2'(DECIM - 1));
  assign blk_done = sample_valid_i && !clear_i && last;
  // Adding half an LSB before the arithmetic shift rounds half toward +inf.
  assign result   = SIGNAL_BITS'((sum + ACC_BITS'(DECIM / 2)) >>> LOG2);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear_i) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_valid_i) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + LOG2'(1);
      end
    end
  end

  decim_hold_reg #(
    .W(SIGNAL_BITS)
  ) u_hold (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load        (blk_done),
    .data        (result),
    .avg_ready_i (avg_ready_i),
    .drop        (drop),
    .avg_o       (avg_o),
    .avg_valid_o (avg_valid_o)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      overrun_o    <= 1'b0;
      drop_count_o <= '0;
    end else if (drop) begin
      overrun_o <= 1'b1;
      if (drop_count_o != '1) drop_count_o <= drop_count_o + DROP_BITS'(1);
    end
  end

endmodule

// File: tb/tb_iir_output_decimator.sv
// Self-checking bench: directed cases plus randomized traffic against a block-level model.
module tb_iir_output_decimator;
  import iir_pkg::*;

  localparam int SB = 24;
  localparam int DM = 4;
  localparam int DB = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 clr = 1'b0;
  logic                 sv = 1'b0;
  logic                 rdy = 1'b1;
  sample_t              smp = '0;
  logic signed [SB-1:0] avg;
  logic                 avg_valid;
  logic                 overrun;
  logic [DB-1:0]        drops;

  int total = 0;
  int bad   = 0;

  longint blk_sum;
  int     blk_n;
  bit     m_valid;
  bit     m_ovr;
  longint m_avg;
  int     m_drops;

  iir_output_decimator #(
    .SIGNAL_BITS (SB),
    .DECIM       (DM),
    .DROP_BITS   (DB)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_n),
    .clear_i        (clr),
    .sample_i       (smp),
    .sample_valid_i (sv),
    .avg_o          (avg),
    .avg_valid_o    (avg_valid),
    .avg_ready_i    (rdy),
    .overrun_o      (overrun),
    .drop_count_o   (drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Rounded mean, half toward +inf, using floor division.
  function automatic longint rmean(input longint s);
    longint t, q;
    t = s + DM / 2;
    q = t / DM;
    if (t < 0 && (t % DM) != 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    blk_sum = 0; blk_n = 0;
    m_valid = 0; m_ovr = 0; m_avg = 0; m_drops = 0;
  endtask

  task automatic check_outputs();
    chk("valid",   avg_valid, m_valid);
    chk("avg",     avg, m_avg);
    chk("overrun", overrun, m_ovr);
    chk("drops",   drops, m_drops);
  endtask

  task automatic cycle(input bit v, input int s, input bit c, input bit r);
    bit     done;
    longint res;
    done = 0; res = 0;
    sv = v; smp = s[SB-1:0]; clr = c; rdy = r;
    @(posedge clk);
    if (c) begin
      blk_sum = 0; blk_n = 0;
    end else if (v) begin
      blk_sum += s; blk_n++;
      if (blk_n == DM) begin
        done = 1; res = rmean(blk_sum); blk_sum = 0; blk_n = 0;
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_avg = res; m_valid = 1;
      end else begin
        m_ovr = 1;
        if (m_drops < 2**DB - 1) m_drops++;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    sv = 0; clr = 0;
    reset_n = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic block4(input int a, input int b, input int c, input int d, input bit r);
    cycle(1, a, 0, r); cycle(1, b, 0, r); cycle(1, c, 0, r); cycle(1, d, 0, r);
  endtask

  initial begin
    int s, ph;
    bit v, c, r;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    reset_n = 1;

    // 1: basic average and latency
    block4(1, 2, 3, 4, 1);
    chk("t1_avg", avg, 3);
    chk("t1_valid", avg_valid, 1);
    cycle(0, 0, 0, 1);

    // 2: negative rounding, then positive
    block4(-1, -1, -1, -2, 1);
    chk("t2a_avg", avg, -1);
    block4(5, 5, 5, 6, 1);
    chk("t2b_avg", avg, 5);
    cycle(0, 0, 0, 1);

    // 3: full-scale extremes
    block4(8388607, 8388607, 8388607, 8388607, 1);
    chk("t3a_avg", avg, 8388607);
    block4(-8388608, -8388608, -8388608, -8388608, 1);
    chk("t3b_avg", avg, -8388608);
    cycle(0, 0, 0, 1);

    // 4: back-pressure drops the second block
    block4(1, 2, 3, 4, 0);
    block4(5, 6, 7, 8, 0);
    chk("t4_avg_held", avg, 3);
    chk("t4_overrun", overrun, 1);
    chk("t4_drops", drops, 1);
    cycle(0, 0, 0, 1);
    chk("t4_valid_fell", avg_valid, 0);

    // 5: clear coincident with third strobe
    cycle(1, 100, 0, 1); cycle(1, 100, 0, 1); cycle(1, 100, 1, 1);
    chk("t5_no_early", avg_valid, 0);
    block4(8, 8, 8, 8, 1);
    chk("t5_avg", avg, 8);
    cycle(0, 0, 0, 1);

    // 6: reset mid-block with a pending result
    block4(9, 9, 9, 9, 0);
    cycle(1, 7, 0, 0); cycle(1, 7, 0, 0);
    do_reset();
    chk("t6_avg_rst", avg, 0);
    block4(8, 8, 8, 8, 1);
    chk("t6_avg", avg, 8);
    cycle(0, 0, 0, 1);

    // randomized traffic with varying back-pressure
    for (int i = 0; i < 4000; i++) begin
      ph = (i / 400) % 4;
      if ($urandom_range(0, 3) == 0)
        s = ($urandom_range(0, 1) != 0) ? 8388607 : -8388608;
      else
        s = int'($urandom_range(0, 24'hFF_FFFF)) - 8388608;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      case (ph)
        0: r = 1;
        1: r = ($urandom_range(0, 1) != 0);
        2: r = ($urandom_range(0, 9) == 0);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      if ($urandom_range(0, 699) == 0) do_reset();
      else cycle(v, s, c, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
